// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache with
// one word per line. Load hits answer combinationally; misses and stores stall
// the pipeline while a request/ack transaction runs on the memory port.
// Optional load hit/miss counters are built when DCACHE_STATS_EN is defined.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | serve load hits, launch miss fills and write-throughs
// READ_MISS  | word read outstanding; fill line on ack
// WRITE_THRU | store outstanding; merge into line on ack if it hits
module data_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n_i,
    input  logic                  memory_instruction_i,
    input  logic                  write_enable_i,
    input  logic                  byte_op_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_wstrb_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_MISS  = 2'd1,
        WRITE_THRU = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES];
    logic                  done;

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit;
    logic                  load_hit;
    logic [DATA_WIDTH-1:0] line_word;
    logic [7:0]            line_byte;
    logic [3:0]            store_strb;
    logic [DATA_WIDTH-1:0] store_data;
    logic [DATA_WIDTH-1:0] merged_word;

    assign offset    = address_i[1:0];
    assign index     = address_i[INDEX_BITS+1:2];
    assign tag       = address_i[ADDR_WIDTH-1:INDEX_BITS+2];
    assign line_word = data_mem[index];
    assign line_byte = line_word[{offset, 3'b000} +: 8];

    assign hit      = memory_instruction_i && valid[index] && (tag_mem[index] == tag);
    assign load_hit = hit && !write_enable_i;

    assign store_strb = byte_op_i ? (4'b0001 << offset) : 4'b1111;
    assign store_data = byte_op_i ? {4{write_data_i[7:0]}} : write_data_i;

    // Load result: word or zero-extended byte on a load hit, otherwise zero.
    always_comb begin
        rd_o = '0;
        if (load_hit) begin
            if (byte_op_i) rd_o = {{(DATA_WIDTH-8){1'b0}}, line_byte};
            else           rd_o = line_word;
        end
    end

    // Byte-lane merge of a store into the currently cached word.
    always_comb begin
        merged_word = line_word;
        for (int i = 0; i < 4; i++) begin
            if (store_strb[i]) merged_word[i*8 +: 8] = store_data[i*8 +: 8];
        end
    end

    // The done flag lets the held store retire for one cycle without re-issuing.
    assign stall_o = (state != IDLE) ||
                     (memory_instruction_i && !load_hit && !(write_enable_i && done));

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (memory_instruction_i) begin
                    if (write_enable_i) begin
                        if (!done) state_nxt = WRITE_THRU;
                    end else if (!hit) begin
                        state_nxt = READ_MISS;
                    end
                end
            end
            READ_MISS, WRITE_THRU: begin
                if (mem_ack_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, valid bits, done flag and the registered memory request.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            done        <= 1'b0;
            valid       <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state == WRITE_THRU) && mem_ack_i;
            if (state == READ_MISS && mem_ack_i) valid[index] <= 1'b1;
            if (state == IDLE && state_nxt == READ_MISS) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= {tag, index, 2'b00};
                mem_wdata_o <= '0;
                mem_wstrb_o <= 4'b0000;
            end else if (state == IDLE && state_nxt == WRITE_THRU) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b1;
                mem_addr_o  <= {tag, index, 2'b00};
                mem_wdata_o <= store_data;
                mem_wstrb_o <= store_strb;
            end else if (state != IDLE && mem_ack_i) begin
                mem_req_o   <= 1'b0;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= '0;
                mem_wdata_o <= '0;
                mem_wstrb_o <= 4'b0000;
            end
        end
    end

    // Tag and data arrays: filled on a read ack, merged on a store hit ack.
    always_ff @(posedge clk) begin
        if (state == READ_MISS && mem_ack_i) begin
            tag_mem[index]  <= tag;
            data_mem[index] <= mem_rdata_i;
        end else if (state == WRITE_THRU && mem_ack_i && hit) begin
            data_mem[index] <= merged_word;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    // Saturating load hit/miss counters.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && load_hit && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 32'd1;
            if (state == IDLE && state_nxt == READ_MISS && miss_count != 32'hFFFF_FFFF)
                miss_count <= miss_count + 32'd1;
        end
    end

    assign hit_count_o  = hit_count;
    assign miss_count_o = miss_count;
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed testbench for data_cache with a hand-driven memory port.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        memory_instruction_i;
    logic        write_enable_i;
    logic        byte_op_i;
    logic [31:0] address_i;
    logic [31:0] write_data_i;
    logic [31:0] rd_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;

    int checks = 0;
    int errors = 0;

`ifdef DCACHE_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    always #5 clk = ~clk;

    data_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .INDEX_BITS(6)) dut (
        .clk                  (clk),
        .rst_n_i              (rst_n_i),
        .memory_instruction_i (memory_instruction_i),
        .write_enable_i       (write_enable_i),
        .byte_op_i            (byte_op_i),
        .address_i            (address_i),
        .write_data_i         (write_data_i),
        .rd_o                 (rd_o),
        .stall_o              (stall_o),
        .mem_req_o            (mem_req_o),
        .mem_we_o             (mem_we_o),
        .mem_addr_o           (mem_addr_o),
        .mem_wdata_o          (mem_wdata_o),
        .mem_wstrb_o          (mem_wstrb_o),
        .mem_ack_i            (mem_ack_i),
        .mem_rdata_i          (mem_rdata_i),
        .hit_count_o          (hit_count_o),
        .miss_count_o         (miss_count_o)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        step();
        memory_instruction_i = 1'b0;
        write_enable_i       = 1'b0;
        byte_op_i            = 1'b0;
        address_i            = '0;
        write_data_i         = '0;
        mem_ack_i            = 1'b0;
        mem_rdata_i          = '0;
    endtask

    task automatic apply_reset();
        rst_n_i = 1'b0;
        memory_instruction_i = 1'b0;
        write_enable_i = 1'b0;
        byte_op_i = 1'b0;
        address_i = '0;
        write_data_i = '0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n_i = 1'b1;
        step();
    endtask

    // Presents one access at cycle start, acks the memory request after
    // ack_wait waiting cycles, and returns at the negedge of the first
    // cycle with stall_o low, with the access still held.
    task automatic access(input logic [31:0] a, input logic w, input logic b,
                          input logic [31:0] wd, input int ack_wait, input logic [31:0] rdata,
                          output int stalls, output logic saw_read,
                          output logic [31:0] q_addr, output logic [31:0] q_wdata,
                          output logic [3:0] q_wstrb, output logic q_we);
        int   waited;
        logic seen;
        waited = 0; seen = 1'b0; stalls = 0; saw_read = 1'b0;
        q_addr = '0; q_wdata = '0; q_wstrb = '0; q_we = 1'b0;
        memory_instruction_i = 1'b1;
        write_enable_i       = w;
        byte_op_i            = b;
        address_i            = a;
        write_data_i         = wd;
        for (int k = 0; k < 40; k++) begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = '0;
            if (mem_req_o) begin
                if (!seen) begin
                    q_addr = mem_addr_o; q_wdata = mem_wdata_o;
                    q_wstrb = mem_wstrb_o; q_we = mem_we_o; seen = 1'b1;
                end
                if (!mem_we_o) saw_read = 1'b1;
                if (waited == ack_wait) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = rdata;
                end
                waited++;
            end
            @(negedge clk);
            if (!stall_o) return;
            stalls++;
            step();
        end
        checks++; errors++;
        $display("FAIL access_timeout: addr %h stalled %0d cycles, required fewer than 40", a, stalls);
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
        checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
        checks++; if (mem_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata_o); end
        checks++; if (mem_wstrb_o !== 4'h0) begin errors++; $display("FAIL reset_wstrb: got %h want 0", mem_wstrb_o); end
        checks++; if (rd_o !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h want 0", rd_o); end
        checks++; if (hit_count_o !== 32'h0 || miss_count_o !== 32'h0) begin
            errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", hit_count_o, miss_count_o);
        end
    endtask

    task automatic test_cold_miss();
        int st; logic rdm, qwe; logic [31:0] qa, qd; logic [3:0] qs;
        access(32'h100, 1'b0, 1'b0, 32'h0, 3, 32'hDEADBEEF, st, rdm, qa, qd, qs, qwe);
        checks++; if (st != 5) begin errors++; $display("FAIL cold_stall_cycles: got %0d want 5", st); end
        checks++; if (qa !== 32'h100 || qwe !== 1'b0) begin errors++; $display("FAIL cold_req: got addr %h we %b want 100/0", qa, qwe); end
        checks++; if (rd_o !== 32'hDEADBEEF) begin errors++; $display("FAIL cold_rd: got %h want deadbeef", rd_o); end
        go_idle();
        access(32'h100, 1'b0, 1'b0, 32'h0, 0, 32'h0, st, rdm, qa, qd, qs, qwe);
        checks++; if (st != 0 || rdm) begin errors++; $display("FAIL reload_hit: got stalls %0d read %b want 0/0", st, rdm); end
        checks++; if (rd_o !== 32'hDEADBEEF) begin errors++; $display("FAIL reload_rd: got %h want deadbeef", rd_o); end
        go_idle();
    endtask

    task automatic test_byte_load();
        int st; logic rdm, qwe; logic [31:0] qa, qd; logic [3:0] qs;
        access(32'h102, 1'b0, 1'b1, 32'h0, 0, 32'h0, st, rdm, qa, qd, qs, qwe);
        checks++; if (st != 0) begin errors++; $display("FAIL lbu102_stall: got %0d want 0", st); end
        checks++; if (rd_o !== 32'h000000AD) begin errors++; $display("FAIL lbu102_rd: got %h want 000000ad", rd_o); end
        go_idle();
        access(32'h103, 1'b0, 1'b1, 32'h0, 0, 32'h0, st, rdm, qa, qd, qs, qwe);
        checks++; if (rd_o !== 32'h000000DE) begin errors++; $display("FAIL lbu103_rd: got %h want 000000de", rd_o); end
        go_idle();
        access(32'h101, 1'b0, 1'b0, 32'h0, 0, 32'h0, st, rdm, qa, qd, qs, qwe);
        checks++; if (rd_o !== 32'hDEADBEEF || st != 0) begin errors++; $display("FAIL lw101_rd: got %h stalls %0d want deadbeef/0", rd_o, st); end
        go_idle();
    endtask

    task automatic test_byte_store();
        int st; logic rdm, qwe; logic [31:0] qa, qd; logic [3:0] qs;
        access(32'h101, 1'b1, 1'b1, 32'hABCDEF55, 0, 32'h0, st, rdm, qa, qd, qs, qwe);
        checks++; if (st != 2) begin errors++; $display("FAIL sb_stall_cycles: got %0d want 2", st); end
        checks++; if (qs !== 4'b0010) begin errors++; $display("FAIL sb_wstrb: got %b want 0010", qs); end
        checks++; if (qd !== 32'h55555555) begin errors++; $display("FAIL sb_wdata: got %h want 55555555", qd); end
        checks++; if (qa !== 32'h100 || qwe !== 1'b1) begin errors++; $display("FAIL sb_req: got addr %h we %b want 100/1", qa, qwe); end
        go_idle();
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL sb_no_reissue: got req %b want 0", mem_req_o); end
        access(32'h100, 1'b0, 1'b0, 32'h0, 0, 32'h0, st, rdm, qa, qd, qs, qwe);
        checks++; if (st != 0 || rd_o !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_merge: got %h stalls %0d want dead55ef/0", rd_o, st); end
        go_idle();
    endtask

    task automatic test_store_miss();
        int st; logic rdm, qwe; logic [31:0] qa, qd; logic [3:0] qs;
        access(32'h200, 1'b1, 1'b0, 32'h12345678, 1, 32'h0, st, rdm, qa, qd, qs, qwe);
        checks++; if (st != 3) begin errors++; $display("FAIL sw_stall_cycles: got %0d want 3", st); end
        checks++; if (qs !== 4'b1111 || qd !== 32'h12345678) begin errors++; $display("FAIL sw_req: got strb %b data %h want 1111/12345678", qs, qd); end
        go_idle();
        access(32'h100, 1'b0, 1'b0, 32'h0, 0, 32'h0, st, rdm, qa, qd, qs, qwe);
        checks++; if (st != 0 || rd_o !== 32'hDEAD55EF) begin errors++; $display("FAIL sw_no_allocate_keep: got %h stalls %0d want dead55ef/0", rd_o, st); end
        go_idle();
        access(32'h200, 1'b0, 1'b0, 32'h0, 0, 32'hCAFEF00D, st, rdm, qa, qd, qs, qwe);
        checks++; if (!rdm || st != 2) begin errors++; $display("FAIL sw_then_load_miss: got read %b stalls %0d want 1/2", rdm, st); end
        checks++; if (rd_o !== 32'hCAFEF00D) begin errors++; $display("FAIL sw_then_load_rd: got %h want cafef00d", rd_o); end
        go_idle();
    endtask

    task automatic test_conflict();
        int st; logic rdm, qwe; logic [31:0] qa, qd; logic [3:0] qs;
        logic [31:0] exp_cnt;
        apply_reset();
        access(32'h100, 1'b0, 1'b0, 32'h0, 0, 32'h11111111, st, rdm, qa, qd, qs, qwe);
        checks++; if (!rdm || rd_o !== 32'h11111111) begin errors++; $display("FAIL conf_a: got read %b rd %h want 1/11111111", rdm, rd_o); end
        go_idle();
        access(32'h200, 1'b0, 1'b0, 32'h0, 0, 32'h22222222, st, rdm, qa, qd, qs, qwe);
        checks++; if (!rdm || rd_o !== 32'h22222222 || qa !== 32'h200) begin errors++; $display("FAIL conf_b: got read %b rd %h addr %h want 1/22222222/200", rdm, rd_o, qa); end
        go_idle();
        access(32'h100, 1'b0, 1'b0, 32'h0, 0, 32'h33333333, st, rdm, qa, qd, qs, qwe);
        checks++; if (!rdm || rd_o !== 32'h33333333) begin errors++; $display("FAIL conf_evict: got read %b rd %h want 1/33333333", rdm, rd_o); end
        go_idle();
        exp_cnt = (STATS != 0) ? 32'd3 : 32'd0;
        checks++; if (miss_count_o !== exp_cnt) begin errors++; $display("FAIL miss_count: got %0d want %0d", miss_count_o, exp_cnt); end
        checks++; if (hit_count_o !== exp_cnt) begin errors++; $display("FAIL hit_count: got %0d want %0d", hit_count_o, exp_cnt); end
    endtask

    task automatic test_reset_mid_miss();
        int st; logic rdm, qwe; logic [31:0] qa, qd; logic [3:0] qs;
        memory_instruction_i = 1'b1;
        write_enable_i = 1'b0;
        byte_op_i = 1'b0;
        address_i = 32'h300;
        step();
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL midrst_req_before: got %b want 1", mem_req_o); end
        #2 rst_n_i = 1'b0;
        #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL midrst_req_drop: got %b want 0", mem_req_o); end
        memory_instruction_i = 1'b0;
        @(negedge clk);
        rst_n_i = 1'b1;
        step();
        access(32'h300, 1'b0, 1'b0, 32'h0, 0, 32'h0BADF00D, st, rdm, qa, qd, qs, qwe);
        checks++; if (!rdm || st != 2) begin errors++; $display("FAIL midrst_reload_miss: got read %b stalls %0d want 1/2", rdm, st); end
        checks++; if (rd_o !== 32'h0BADF00D) begin errors++; $display("FAIL midrst_rd: got %h want 0badf00d", rd_o); end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_byte_load();
        test_byte_store();
        test_store_miss();
        test_conflict();
        test_reset_mid_miss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
